fetch_sequencer: RTL and testbench

- Sequences the instruction-fetch stage of the MIPS pipeline.
- Owns the PC and issues one-outstanding req/ack fetches to instruction memory.
- Applies redirects (jr > j > branch > pc+4), honours the hazard-unit stall, flushes wrong-path fetches and stops fetching on the halt word.
- Output feeds the IF/ID register as inst, pc4 and inst_valid.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_next_pc.sv | 45 ++++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its next-PC mux.
// Pure declarations: no latency, no backpressure.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_DRAIN,
        S_HALT
    } fetch_state_t;

    typedef enum logic [1:0] {
        NEXT_SEQ,
        NEXT_BR,
        NEXT_J,
        NEXT_JR
    } next_sel_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

endpackage

// File: rtl/fetch_next_pc.sv
// Priority mux for the redirect target: jr > j > branch > sequential.
// Purely combinational, zero latency; no backpressure.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic        jump_register,
    input  logic        jump,
    input  logic        pc_src,
    input  logic [31:0] rs_data,
    input  logic [31:0] inst,
    input  logic [31:0] pc4,
    input  logic [31:0] baddr,
    output logic [31:0] target,
    output logic        redirect_taken
);

    next_sel_t sel;
    logic      unused_bits;

    // Opcode bits and the low register bits never contribute to a target.
    assign unused_bits = ^{inst[31:26], rs_data[1:0]};

    always_comb begin
        sel = NEXT_SEQ;
        if (jump_register) begin
            sel = NEXT_JR;
        end else if (jump) begin
            sel = NEXT_J;
        end else if (pc_src) begin
            sel = NEXT_BR;
        end
    end

    always_comb begin
        target         = pc4;
        redirect_taken = 1'b1;
        case (sel)
            NEXT_JR: target = {rs_data[31:2], 2'b00};
            NEXT_J:  target = {pc4[31:28], inst[25:0], 2'b00};
            NEXT_BR: target = baddr;
            default: redirect_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, one outstanding imem fetch, redirects, drain and halt.
// Latency: zero-wait ack delivers inst on the next edge; stall holds IF/ID and blocks new requests.
// Optional FETCH_PERF_CNT_EN adds stall_cycles / flush_count counters that freeze once halted.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] baddr,
    input  logic        jump,
    input  logic        jump_register,
    input  logic [31:0] rs_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc4,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  held_addr;
    logic [31:0]  target;
    logic         in_flight;
    logic         redirect_taken;
    logic         consume;
    logic         redirect;
    logic         accept;

    fetch_next_pc u_next_pc (
        .jump_register (jump_register),
        .jump          (jump),
        .pc_src        (pc_src),
        .rs_data       (rs_data),
        .inst          (inst),
        .pc4           (pc4),
        .baddr         (baddr),
        .target        (target),
        .redirect_taken(redirect_taken)
    );

    assign consume  = inst_valid && !stall;
    assign redirect = consume && redirect_taken;

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = in_flight ? held_addr : pc;
        accept    = 1'b0;
        state_nxt = state;
        case (state)
            S_REQ: begin
                // A request already out must stay up; a new one waits for a free or draining slot.
                imem_req = !rst && (in_flight || !inst_valid || !stall);
                accept   = imem_req && imem_ack && !redirect;
                if (redirect && imem_req && !imem_ack) begin
                    state_nxt = S_DRAIN;
                end else if (accept && imem_rdata == HALT_WORD) begin
                    state_nxt = S_HALT;
                end
            end
            S_DRAIN: begin
                imem_req = !rst;
                if (imem_ack) begin
                    state_nxt = S_REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            in_flight  <= 1'b0;
            held_addr  <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            pc4        <= '0;
            halted     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (imem_req && !imem_ack) begin
                in_flight <= 1'b1;
                held_addr <= imem_addr;
            end else if (imem_ack) begin
                in_flight <= 1'b0;
            end

            if (redirect) begin
                pc <= target;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end

            if (accept) begin
                inst       <= imem_rdata;
                pc4        <= pc + 32'd4;
                inst_valid <= 1'b1;
                if (imem_rdata == HALT_WORD) begin
                    halted <= 1'b1;
                end
            end else if (consume) begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (state != S_HALT) begin
            if (stall && inst_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized program-order reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT     = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0, pc_src = 1'b0, jump = 1'b0, jump_register = 1'b0;
    logic [31:0] baddr = '0, rs_data = '0;
    logic [31:0] inst, pc4;
    logic        inst_valid, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    fetch_sequencer #(.RESET_PC(RESET_PC), .HALT_WORD(HALT)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .pc_src       (pc_src),
        .baddr        (baddr),
        .jump         (jump),
        .jump_register(jump_register),
        .rs_data      (rs_data),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc4          (pc4),
        .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Memory responder state: latency < 0 means random 0..3 cycles.
    int          mem_lat = 0;
    bit          mem_hold = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0, mem_need = 0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_addr = '0, ovr_data = '0;

    logic        obs_req, obs_ack, obs_iv, obs_halted;
    logic [31:0] obs_addr, obs_inst, obs_pc4;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        if (ovr_en && a == ovr_addr) return ovr_data;
        w = a * 32'h9E37_79B1 + 32'h1357_9BDF;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic step();
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        imem_ack = 1'b0;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_need = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (!mem_hold && mem_cnt >= mem_need) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(imem_addr);
                mem_busy   = 1'b0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_busy = 1'b0;
        end
        obs_ack = imem_ack;
        #1;
        obs_iv     = inst_valid;
        obs_inst   = inst;
        obs_pc4    = pc4;
        obs_halted = halted;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0; pc_src = 1'b0; jump = 1'b0; jump_register = 1'b0;
        mem_busy = 1'b0; mem_hold = 1'b0; mem_lat = 0; ovr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || pc4 !== 32'h0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: got iv=%b inst=%h pc4=%h halted=%b expected all 0", inst_valid, inst, pc4, halted);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", stall_cycles, flush_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] ea;
        mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            ea = 32'(4 * i);
            step();
            n_cmp++;
            if (obs_req !== 1'b1 || obs_addr !== ea) begin
                n_fail++; $display("FAIL zw_addr[%0d]: got req=%b addr=%h expected 1/%h", i, obs_req, obs_addr, ea);
            end
            n_cmp++;
            if (obs_iv !== (i >= 1)) begin
                n_fail++; $display("FAIL zw_valid[%0d]: got %b expected %b", i, obs_iv, (i >= 1));
            end else if (i >= 1 && (obs_inst !== word_at(ea - 32'd4) || obs_pc4 !== ea)) begin
                n_fail++; $display("FAIL zw_inst[%0d]: got %h/%h expected %h/%h", i, obs_inst, obs_pc4, word_at(ea - 32'd4), ea);
            end
        end
    endtask

    task automatic test_stall();
        int rises, acks;
        bit prev;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] c0;
        c0 = stall_cycles;
`endif
        stall = 1'b1;
        mem_lat = 3;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (obs_req !== 1'b0 || obs_iv !== 1'b1 || obs_inst !== word_at(32'hC) || obs_pc4 !== 32'h10) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got req=%b iv=%b inst=%h pc4=%h expected 0/1/%h/00000010",
                                   i, obs_req, obs_iv, obs_inst, obs_pc4, word_at(32'hC));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles - c0 !== 32'd4) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 4", stall_cycles - c0); end
`endif
        stall = 1'b0;
        rises = 0; acks = 0; prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_req && !prev) rises++;
            prev = obs_req;
            if (obs_ack) acks++;
            stall = 1'b1;
        end
        n_cmp++;
        if (rises != 1 || acks != 1) begin n_fail++; $display("FAIL stall_release: got rises=%0d acks=%0d expected 1/1", rises, acks); end
        n_cmp++;
        if (obs_iv !== 1'b1 || obs_inst !== word_at(32'h10) || obs_pc4 !== 32'h14) begin
            n_fail++; $display("FAIL stall_fetch: got iv=%b inst=%h pc4=%h expected 1/%h/00000014", obs_iv, obs_inst, obs_pc4, word_at(32'h10));
        end
    endtask

    task automatic test_jump();
        do_reset();
        ovr_en = 1'b1; ovr_addr = 32'h4; ovr_data = 32'h0800_0010;
        step();
        step();
        jump = 1'b1;
        step();
        n_cmp++;
        if (obs_inst !== 32'h0800_0010 || obs_pc4 !== 32'h8 || obs_ack !== 1'b1 || obs_addr !== 32'h8) begin
            n_fail++; $display("FAIL jump_setup: got inst=%h pc4=%h ack=%b addr=%h", obs_inst, obs_pc4, obs_ack, obs_addr);
        end
        jump = 1'b0;
        step();
        n_cmp++;
        if (obs_iv !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h40) begin
            n_fail++; $display("FAIL jump_target: got iv=%b req=%b addr=%h expected 0/1/00000040", obs_iv, obs_req, obs_addr);
        end
        step();
        n_cmp++;
        if (obs_iv !== 1'b1 || obs_inst !== word_at(32'h40) || obs_pc4 !== 32'h44) begin
            n_fail++; $display("FAIL jump_deliver: got iv=%b inst=%h pc4=%h expected 1/%h/00000044", obs_iv, obs_inst, obs_pc4, word_at(32'h40));
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (flush_count !== 32'd1) begin n_fail++; $display("FAIL jump_flush_cnt: got %0d expected 1", flush_count); end
`endif
    endtask

    task automatic test_drain();
        do_reset();
        step();
        jump_register = 1'b1; pc_src = 1'b1; rs_data = 32'h0000_0103; baddr = 32'h200;
        mem_hold = 1'b1;
        step();
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h4 || obs_ack !== 1'b0) begin
            n_fail++; $display("FAIL drain_issue: got req=%b addr=%h ack=%b expected 1/00000004/0", obs_req, obs_addr, obs_ack);
        end
        jump_register = 1'b0; pc_src = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h4 || obs_iv !== 1'b0) begin
                n_fail++; $display("FAIL drain_hold[%0d]: got req=%b addr=%h iv=%b expected 1/00000004/0", i, obs_req, obs_addr, obs_iv);
            end
        end
        mem_hold = 1'b0; stall = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs_iv !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            n_fail++; $display("FAIL drain_next: got iv=%b req=%b addr=%h expected 0/1/00000100", obs_iv, obs_req, obs_addr);
        end
        step();
        n_cmp++;
        if (obs_iv !== 1'b1 || obs_inst !== word_at(32'h100) || obs_pc4 !== 32'h104) begin
            n_fail++; $display("FAIL drain_deliver: got iv=%b inst=%h pc4=%h expected 1/%h/00000104", obs_iv, obs_inst, obs_pc4, word_at(32'h100));
        end
    endtask

    task automatic test_halt();
        int req_hi;
        do_reset();
        ovr_en = 1'b1; ovr_addr = 32'h8; ovr_data = HALT;
        step();
        step();
        step();
        n_cmp++;
        if (obs_ack !== 1'b1 || obs_addr !== 32'h8 || obs_halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_fetch: got ack=%b addr=%h halted=%b expected 1/00000008/0", obs_ack, obs_addr, obs_halted);
        end
        step();
        n_cmp++;
        if (obs_halted !== 1'b1 || obs_iv !== 1'b1 || obs_inst !== HALT || obs_pc4 !== 32'hC) begin
            n_fail++; $display("FAIL halt_capture: got halted=%b iv=%b inst=%h pc4=%h expected 1/1/%h/0000000c", obs_halted, obs_iv, obs_inst, obs_pc4, HALT);
        end
        req_hi = 0;
        for (int i = 0; i < 22; i++) begin
            step();
            if (obs_req) req_hi++;
        end
        n_cmp++;
        if (req_hi != 0 || obs_iv !== 1'b0 || obs_halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_quiet: got req_cycles=%0d iv=%b halted=%b expected 0/0/1", req_hi, obs_iv, obs_halted);
        end
        do_reset();
        ovr_en = 1'b1; ovr_addr = 32'h4; ovr_data = HALT;
        step();
        pc_src = 1'b1; baddr = 32'h80;
        step();
        pc_src = 1'b0;
        step();
        n_cmp++;
        if (obs_halted !== 1'b0 || obs_iv !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h80) begin
            n_fail++; $display("FAIL halt_redirect: got halted=%b iv=%b req=%b addr=%h expected 0/0/1/00000080", obs_halted, obs_iv, obs_req, obs_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        jump_register = 1'b1; rs_data = 32'hFFFF_FFFE;
        step();
        jump_register = 1'b0;
        step();
        n_cmp++;
        if (obs_addr !== 32'hFFFF_FFFC || obs_ack !== 1'b1) begin
            n_fail++; $display("FAIL wrap_fetch: got addr=%h ack=%b expected fffffffc/1", obs_addr, obs_ack);
        end
        step();
        n_cmp++;
        if (obs_iv !== 1'b1 || obs_pc4 !== 32'h0 || obs_inst !== word_at(32'hFFFF_FFFC) || obs_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc: got iv=%b pc4=%h inst=%h addr=%h expected 1/00000000/%h/00000000",
                               obs_iv, obs_pc4, obs_inst, obs_addr, word_at(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, w, p4, prev_addr;
        int consumed, redirs;
        bit prev_req, prev_ack;
        do_reset();
        mem_lat = -1;
        exp_pc = RESET_PC; consumed = 0; redirs = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        for (int c = 0; c < 600; c++) begin
            stall         = ($urandom_range(0, 3) == 0);
            jump_register = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            pc_src        = ($urandom_range(0, 7) == 0);
            rs_data       = $urandom;
            baddr         = $urandom & 32'hFFFF_FFFC;
            step();
            if (prev_req && !prev_ack) begin
                n_cmp++;
                if (obs_req !== 1'b1 || obs_addr !== prev_addr) begin
                    n_fail++; $display("FAIL rnd_hold[%0d]: got req=%b addr=%h expected 1/%h", c, obs_req, obs_addr, prev_addr);
                end
            end
            if (obs_iv === 1'b1 && !stall) begin
                w  = word_at(exp_pc);
                p4 = exp_pc + 32'd4;
                n_cmp++;
                if (obs_inst !== w || obs_pc4 !== p4) begin
                    n_fail++; $display("FAIL rnd_inst[%0d]: got %h/%h expected %h/%h", c, obs_inst, obs_pc4, w, p4);
                end
                consumed++;
                if (jump_register) begin
                    exp_pc = {rs_data[31:2], 2'b00}; redirs++;
                end else if (jump) begin
                    exp_pc = {p4[31:28], w[25:0], 2'b00}; redirs++;
                end else if (pc_src) begin
                    exp_pc = baddr; redirs++;
                end else begin
                    exp_pc = p4;
                end
            end
            prev_req = obs_req; prev_ack = obs_ack; prev_addr = obs_addr;
        end
        n_cmp++;
        if (consumed < 60) begin n_fail++; $display("FAIL rnd_progress: got %0d consumed expected >= 60", consumed); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (flush_count !== 32'(redirs)) begin n_fail++; $display("FAIL rnd_flush_cnt: got %0d expected %0d", flush_count, redirs); end
`endif
        stall = 1'b0; jump_register = 1'b0; jump = 1'b0; pc_src = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            stall = (k == 3);
            step();
            if (obs_req && obs_ack && obs_addr == 32'h20) begin
                mem_lat = 3;
                found = 1'b1;
            end
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if (!found || obs_req !== 1'b1 || obs_addr !== 32'h24 || obs_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_setup: got found=%b req=%b addr=%h ack=%b expected 1/1/00000024/0", found, obs_req, obs_addr, obs_ack);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop: got req=%b iv=%b expected 0/0", imem_req, inst_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_cnt: got %h/%h expected 0/0", stall_cycles, flush_count);
        end
`endif
        mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 0;
        step();
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            n_fail++; $display("FAIL rstmid_restart: got req=%b addr=%h expected 1/%h", obs_req, obs_addr, RESET_PC);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_jump();
        test_drain();
        test_halt();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
